// File: rtl/drlp_cfg_seq.sv
// Layer configuration sequencer: fetches six descriptor words per layer, writes them to the
// config bank (start bit set on the last word), waits for the array, then clears the start bit.
module drlp_cfg_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_go,
    input  logic        i_abort,
    input  logic [7:0]  i_layer_num,
    input  logic [11:0] i_desc_base,
    output logic [11:0] o_mem_addr,
    output logic        o_mem_rd_en,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_cfg,
    output logic [2:0]  o_cfg_addr,
    output logic        o_cfg_wr_en,
    input  logic        i_layer_done,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_layer_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_WAIT,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [2:0] START_IDX = 3'd5;

    state_t      state_reg, state_next;
    logic [2:0]  k_reg, k_next;
    logic [7:0]  layer_idx_reg, layer_idx_next;
    logic [7:0]  layer_num_reg, layer_num_next;
    logic [11:0] layer_base_reg, layer_base_next;
    logic [31:0] held_reg, held_next;
    logic        abort_reg, abort_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= S_IDLE;
            k_reg          <= '0;
            layer_idx_reg  <= '0;
            layer_num_reg  <= '0;
            layer_base_reg <= '0;
            held_reg       <= '0;
            abort_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            k_reg          <= k_next;
            layer_idx_reg  <= layer_idx_next;
            layer_num_reg  <= layer_num_next;
            layer_base_reg <= layer_base_next;
            held_reg       <= held_next;
            abort_reg      <= abort_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        k_next          = k_reg;
        layer_idx_next  = layer_idx_reg;
        layer_num_next  = layer_num_reg;
        layer_base_next = layer_base_reg;
        held_next       = held_reg;
        abort_next      = abort_reg;
        o_mem_addr      = '0;
        o_mem_rd_en     = 1'b0;
        o_cfg           = '0;
        o_cfg_addr      = '0;
        o_cfg_wr_en     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (i_go) begin
                    layer_num_next  = i_layer_num;
                    layer_base_next = i_desc_base;
                    layer_idx_next  = '0;
                    k_next          = '0;
                    abort_next      = 1'b0;
                    state_next      = (i_layer_num == 8'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                o_mem_rd_en = 1'b1;
                o_mem_addr  = layer_base_reg + {9'd0, k_reg};
                state_next  = i_abort ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                // An abort here drops the word that would have been written this cycle.
                if (i_abort) begin
                    state_next = S_DONE;
                end else begin
                    o_cfg_wr_en = 1'b1;
                    o_cfg_addr  = k_reg;
                    o_cfg       = i_mem_rdata;
                    if (k_reg == START_IDX) begin
                        o_cfg[0]   = 1'b1;
                        held_next  = {i_mem_rdata[31:1], 1'b0};
                        state_next = S_WAIT;
                    end else begin
                        k_next     = k_reg + 3'd1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    abort_next = 1'b1;
                    state_next = S_CLEAR;
                end else if (i_layer_done) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                o_cfg_wr_en = 1'b1;
                o_cfg_addr  = START_IDX;
                o_cfg       = held_reg;
                // 9-bit compare so a 255-layer run ends on index 254 instead of wrapping.
                if (abort_reg || ({1'b0, layer_idx_reg} + 9'd1 == {1'b0, layer_num_reg})) begin
                    state_next = S_DONE;
                end else begin
                    layer_idx_next  = layer_idx_reg + 8'd1;
                    layer_base_next = layer_base_reg + 12'd6;
                    k_next          = '0;
                    state_next      = S_FETCH;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_busy      = (state_reg != S_IDLE);
    assign o_done      = (state_reg == S_DONE);
    assign o_layer_idx = layer_idx_reg;

endmodule

// File: tb/tb_drlp_cfg_seq.sv
// Bench for drlp_cfg_seq: table of layer sequences with a read/write/done scoreboard,
// plus hand-written reset-state and reset-during-WAIT sequences.
module tb_drlp_cfg_seq;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_go = 1'b0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_layer_num = '0;
    logic [11:0] i_desc_base = '0;
    logic [11:0] o_mem_addr;
    logic        o_mem_rd_en;
    logic [31:0] i_mem_rdata = '0;
    logic [31:0] o_cfg;
    logic [2:0]  o_cfg_addr;
    logic        o_cfg_wr_en;
    logic        i_layer_done = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_layer_idx;

    drlp_cfg_seq dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_go         (i_go),
        .i_abort      (i_abort),
        .i_layer_num  (i_layer_num),
        .i_desc_base  (i_desc_base),
        .o_mem_addr   (o_mem_addr),
        .o_mem_rd_en  (o_mem_rd_en),
        .i_mem_rdata  (i_mem_rdata),
        .o_cfg        (o_cfg),
        .o_cfg_addr   (o_cfg_addr),
        .o_cfg_wr_en  (o_cfg_wr_en),
        .i_layer_done (i_layer_done),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_layer_idx  (o_layer_idx)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] memw(input logic [11:0] a);
        return 32'hA000_0000 + {20'd0, a};
    endfunction

    // Descriptor memory: registered read, data valid the cycle after the strobe.
    always @(posedge i_clk) if (o_mem_rd_en) i_mem_rdata <= memw(o_mem_addr);

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [7:0]  idx;
    } wr_t;

    logic [11:0] exp_rd[$];
    wr_t         exp_wr[$];
    int          exp_done[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_layer(input logic [11:0] bl, input logic [7:0] idx,
                              input int nrd, input int nwr, input bit clr);
        wr_t w;
        for (int k = 0; k < nrd; k++) exp_rd.push_back(bl + 12'(k));
        for (int k = 0; k < nwr; k++) begin
            w.addr = 3'(k);
            w.data = memw(bl + 12'(k));
            if (k == 5) w.data[0] = 1'b1;
            w.idx  = idx;
            exp_wr.push_back(w);
        end
        if (clr) begin
            w.addr = 3'd5;
            w.data = memw(bl + 12'd5) & 32'hFFFF_FFFE;
            w.idx  = idx;
            exp_wr.push_back(w);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    wr_t         mon_w;
    logic [11:0] mon_a;
    int          mon_d;
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_mem_rd_en || o_cfg_wr_en)
                check("strobe_excl", {31'd0, o_mem_rd_en & o_cfg_wr_en}, 32'd0);
            if (o_mem_rd_en) begin
                if (exp_rd.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_read: got addr %h, required no read (cycle %0d)", o_mem_addr, cyc);
                end else begin
                    mon_a = exp_rd.pop_front();
                    check("rd_addr", {20'd0, o_mem_addr}, {20'd0, mon_a});
                end
            end
            if (o_cfg_wr_en) begin
                if (exp_wr.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_write: got idx %0d data %h, required no write (cycle %0d)", o_cfg_addr, o_cfg, cyc);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("cfg_addr", {29'd0, o_cfg_addr}, {29'd0, mon_w.addr});
                    check("cfg_data", o_cfg, mon_w.data);
                    if (mon_w.addr == 3'd5) check("layer_idx", {24'd0, o_layer_idx}, {24'd0, mon_w.idx});
                end
            end
            if (o_done) begin
                if (exp_done.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_done: got o_done at cycle %0d, required none", cyc);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_cycle", cyc, mon_d);
                end
            end
        end
    end

    task automatic check_drained(input string tag);
        check({tag, "_rd_left"}, exp_rd.size(), 32'd0);
        check({tag, "_wr_left"}, exp_wr.size(), 32'd0);
        check({tag, "_done_left"}, exp_done.size(), 32'd0);
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_addr"}, {20'd0, o_mem_addr}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, o_mem_rd_en}, 32'd0);
        check({tag, "_cfg"}, o_cfg, 32'd0);
        check({tag, "_cfg_addr"}, {29'd0, o_cfg_addr}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, o_cfg_wr_en}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, o_done}, 32'd0);
        check({tag, "_layer_idx"}, {24'd0, o_layer_idx}, 32'd0);
    endtask

    // ab_mode: 0 none, 1 abort in WRITE k, 2 abort in WAIT, 3 abort+layer_done in WAIT, 4 abort in CLEAR
    typedef struct {
        logic [7:0]  num;
        logic [11:0] base;
        int          d;
        int          ab_mode;
        int          ab_layer;
        int          ab_k;
        bit          noise;
        int          done_off;
        logic [7:0]  last_idx;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input int vi, input vec_t v);
        int t, per, l, s;
        logic [11:0] bl;
        @(posedge i_clk); #1;
        t = cyc;
        i_go = 1'b1; i_layer_num = v.num; i_desc_base = v.base;
        per = 14 + v.d;
        for (int li = 0; li < int'(v.num); li++) begin
            bl = v.base + 12'(6 * li);
            if (v.ab_mode == 1 && li == v.ab_layer) begin
                push_layer(bl, 8'(li), v.ab_k + 1, v.ab_k, 1'b0);
                break;
            end
            push_layer(bl, 8'(li), 6, 6, 1'b1);
            if ((v.ab_mode == 2 || v.ab_mode == 3) && li == v.ab_layer) break;
        end
        exp_done.push_back(t + v.done_off);
        @(posedge i_clk); #1;
        i_go = 1'b0; i_layer_num = 8'hEE; i_desc_base = 12'hEEE;
        for (int c = t + 1; c <= t + v.done_off + 2; c++) begin
            i_go = 1'b0; i_abort = 1'b0; i_layer_done = 1'b0;
            if (v.noise && c == t + 1) i_layer_done = 1'b1;
            if (v.noise && c == t + 3) begin
                i_go = 1'b1; i_layer_num = 8'd9; i_desc_base = 12'h555;
            end
            l = (c - t - 1) / per;
            s = t + 1 + l * per;
            if (l < int'(v.num) && !(v.ab_mode >= 1 && v.ab_mode <= 3 && l > v.ab_layer)) begin
                if (c == s + 12 + v.d) begin
                    if ((v.ab_mode == 2 || v.ab_mode == 3) && l == v.ab_layer) begin
                        i_abort = 1'b1;
                        i_layer_done = (v.ab_mode == 3);
                    end else if (!(v.ab_mode == 1 && l == v.ab_layer)) begin
                        i_layer_done = 1'b1;
                    end
                end
                if (v.ab_mode == 1 && l == v.ab_layer && c == s + 2 * v.ab_k + 1) i_abort = 1'b1;
                if (v.ab_mode == 4 && l == v.ab_layer && c == s + 13 + v.d) i_abort = 1'b1;
            end
            @(posedge i_clk); #1;
        end
        i_go = 1'b0; i_abort = 1'b0; i_layer_done = 1'b0;
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idx_hold", {24'd0, o_layer_idx}, {24'd0, v.last_idx});
        check_drained("vec");
        $display("vector %0d: num=%0d base=%h abort_mode=%0d done at +%0d", vi, v.num, v.base, v.ab_mode, v.done_off);
    endtask

    initial begin
        int t;
        vecs[0]  = '{8'd1,   12'h010, 2, 0, 0, 0, 1'b0, 17,   8'd0};
        vecs[1]  = '{8'd3,   12'hFFA, 0, 0, 0, 0, 1'b0, 43,   8'd2};
        vecs[2]  = '{8'd0,   12'h200, 0, 0, 0, 0, 1'b0, 1,    8'd0};
        vecs[3]  = '{8'd2,   12'h101, 5, 0, 0, 0, 1'b0, 39,   8'd1};
        vecs[4]  = '{8'd2,   12'h020, 0, 1, 0, 3, 1'b0, 9,    8'd0};
        vecs[5]  = '{8'd3,   12'h040, 1, 2, 0, 0, 1'b0, 16,   8'd0};
        vecs[6]  = '{8'd3,   12'h0A0, 0, 2, 1, 0, 1'b0, 29,   8'd1};
        vecs[7]  = '{8'd2,   12'h080, 3, 3, 0, 0, 1'b0, 18,   8'd0};
        vecs[8]  = '{8'd1,   12'h7F1, 1, 0, 0, 0, 1'b1, 16,   8'd0};
        vecs[9]  = '{8'd2,   12'h300, 0, 4, 0, 0, 1'b0, 29,   8'd1};
        vecs[10] = '{8'd255, 12'h123, 0, 0, 0, 0, 1'b0, 3571, 8'd254};

        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        // Strays in IDLE must produce no traffic and no done.
        i_abort = 1'b1; i_layer_done = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0; i_layer_done = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 check("idle_stray_busy", {31'd0, o_busy}, 32'd0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Reset while in WAIT of layer 1: no clear write, outputs drop asynchronously.
        @(posedge i_clk); #1;
        t = cyc;
        i_go = 1'b1; i_layer_num = 8'd2; i_desc_base = 12'h3C1;
        push_layer(12'h3C1, 8'd0, 6, 6, 1'b1);
        push_layer(12'h3C7, 8'd1, 6, 6, 1'b0);
        @(posedge i_clk); #1;
        i_go = 1'b0;
        while (cyc < t + 13) begin @(posedge i_clk); #1; end
        i_layer_done = 1'b1;
        @(posedge i_clk); #1;
        i_layer_done = 1'b0;
        while (cyc < t + 28) begin @(posedge i_clk); #1; end
        check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        check("pre_rst_idx", {24'd0, o_layer_idx}, 32'd1);
        #1 i_rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        i_layer_done = 1'b1;
        @(posedge i_clk); #1;
        i_layer_done = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 check("post_rst_busy", {31'd0, o_busy}, 32'd0);
        check_drained("rst");
        $display("reset-in-WAIT sequence complete at cycle %0d", cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/drlp_cfg_seq.md
DRLP_CFG_SEQ -- requirements
Module: drlp_cfg_seq

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
- i_clk  in  1  single clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_go  in  1  one-cycle pulse, starts a layer sequence
- i_abort  in  1  one-cycle pulse, terminates the sequence
- i_layer_num  in  8  layers to run; 0 = none
- i_desc_base  in  12  descriptor-memory word address of layer 0
- o_mem_addr  out  12  descriptor-memory read address
- o_mem_rd_en  out  1  descriptor-memory read strobe
- i_mem_rdata  in  32  read data, valid the cycle after o_mem_rd_en
- o_cfg  out  32  config write data to the config register bank
- o_cfg_addr  out  3  config register index 0..5
- o_cfg_wr_en  out  1  config write strobe, one word per cycle
- i_layer_done  in  1  one-cycle pulse from the array, layer finished
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse, sequence finished or aborted
- o_layer_idx  out  8  index of the current layer

Function
REQ-002 Descriptor layout: 6 consecutive 32-bit words per layer; word k goes to config index k; layer n base = i_desc_base + 6*n, modulo 2^12.
REQ-003 i_layer_num and i_desc_base SHALL be captured on the accepted i_go; later changes SHALL be ignored until the next sequence.
REQ-004 FSM states: IDLE, FETCH, WRITE, WAIT, CLEAR, DONE.
REQ-005 IDLE: i_go with captured layer_num > 0 -> FETCH, k=0, layer_idx=0. i_go with layer_num = 0 -> DONE, no memory or config traffic.
REQ-006 FETCH: o_mem_rd_en=1 and o_mem_addr = layer base + k for exactly one cycle, then -> WRITE.
REQ-007 WRITE: o_cfg_wr_en=1, o_cfg_addr=k, o_cfg=i_mem_rdata. For k<5: k++ and -> FETCH. For k=5: o_cfg bit0 is forced to 1 (start), the word is held internally with bit0=0, and the state goes -> WAIT.
REQ-008 Programming a layer takes exactly 12 cycles, 2 per word; the start word (index 5) is always the last write of the layer.
REQ-009 WAIT: no strobes. i_layer_done -> CLEAR. i_layer_done in any other state SHALL be ignored.
REQ-010 CLEAR: one write to index 5 with the held word (start bit 0). Then:
- if layer_idx+1 == layer_num -> DONE
- otherwise layer_idx++, k=0, -> FETCH
REQ-011 DONE: o_done=1 for one cycle, then -> IDLE; o_layer_idx keeps its last value until the next accepted i_go.
REQ-012 i_go while o_busy=1 SHALL be ignored.
REQ-013 i_abort behaviour:
- in FETCH or WRITE -> DONE; the config write in progress that cycle is suppressed
- in WAIT -> CLEAR, then DONE regardless of layer count
- in CLEAR or DONE: ignored
- in IDLE: ignored
REQ-014 i_abort and i_layer_done in the same WAIT cycle: abort priority; exactly one CLEAR write; -> DONE.
REQ-015 o_mem_rd_en and o_cfg_wr_en SHALL never be high in the same cycle; both SHALL be low outside FETCH, WRITE and CLEAR.
REQ-016 layer_idx counter: 8 bits; layer_num=255 runs 255 layers without wrap.

Reset
REQ-017 While i_rst_n=0: state=IDLE, all strobes 0, o_busy=0, o_done=0, o_layer_idx=0, o_mem_addr=0, o_cfg=0, o_cfg_addr=0, captured registers 0.
REQ-018 Reset mid-sequence (including WAIT) SHALL abandon the sequence with no CLEAR write; the downstream config bank is not reset by this block.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- base=0x010, num=1, memory word i = 0xA0000000+i; i_go -> rd addrs 0x010..0x015; writes idx0..4 = memory words; idx5 = 0xA0000015|1; i_layer_done -> CLEAR write idx5 = 0xA0000014; o_done 1 cycle later.
- num=3, base=0xFFA -> layer 1 base 0x000, layer 2 base 0x006 (wrap); 3 start writes; o_layer_idx steps 0,1,2; one o_done.
- num=0 -> o_done in the cycle after i_go; zero strobes.
- i_abort during WRITE k=3 -> no further writes; o_done. i_abort in WAIT -> exactly one clear write; o_done.
- i_layer_done during FETCH, and i_go while busy -> both ignored; sequence timing unchanged.
- i_rst_n low during WAIT -> all outputs reach reset values asynchronously; no clear write.
